// File: rtl/vdp_sprite_meta_pkg.sv
// rtl/vdp_sprite_meta_pkg.sv - register map, block bits and entry layout for the sprite metadata writer
package vdp_sprite_meta_pkg;

  localparam logic [2:0] REG_ADDRESS      = 3'd0;
  localparam logic [2:0] REG_BLOCK_SELECT = 3'd1;
  localparam logic [2:0] REG_DATA         = 3'd2;
  localparam logic [2:0] REG_INCREMENT    = 3'd3;
  localparam logic [2:0] REG_FILL_DATA    = 3'd4;
  localparam logic [2:0] REG_FILL_COUNT   = 3'd5;

  localparam int BLK_X = 0;
  localparam int BLK_Y = 1;
  localparam int BLK_G = 2;

  localparam int ADDR_W  = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = ADDR_W + SEL_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [SEL_W-1:0]  select;
    logic [DATA_W-1:0] data;
  } meta_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/vdp_sprite_meta_writer_if.sv
// rtl/vdp_sprite_meta_writer_if.sv - host register bus between the VDP decoder and the metadata writer
interface vdp_sprite_meta_writer_if;
  logic [2:0]  host_register;
  logic [15:0] host_write_data;
  logic        host_we;
  logic        host_ready;

  modport master (output host_register, host_write_data, host_we, input host_ready);
  modport slave  (input host_register, host_write_data, host_we, output host_ready);
endinterface

// File: rtl/vdp_sprite_meta_fifo.sv
// rtl/vdp_sprite_meta_fifo.sv - small synchronous FIFO for queued metadata writes
module vdp_sprite_meta_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] ptr_one;

  assign ptr_one  = {{AW{1'b0}}, 1'b1};
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + ptr_one;
      if (pop && !empty) rd_ptr <= rd_ptr + ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/vdp_sprite_meta_writer.sv
// rtl/vdp_sprite_meta_writer.sv - host-facing producer for the sprite core metadata write port
// Optional VDP_SPRITE_META_VBLANK_GATE_EN restricts metadata issue to vblank.
module vdp_sprite_meta_writer
  import vdp_sprite_meta_pkg::*;
#(
  parameter int FIFO_DEPTH        = 4,
  parameter int DEFAULT_INCREMENT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  vdp_sprite_meta_writer_if.slave  host,
  input  logic                     vblank,
  output logic [7:0]               meta_address,
  output logic [15:0]              meta_write_data,
  output logic [2:0]               meta_block_select,
  output logic                     meta_we,
  output logic                     busy,
  output logic                     overrun
);
  wr_state_t        state, state_next;
  logic [7:0]       pointer;
  logic [2:0]       block_select;
  logic [7:0]       increment;
  logic [15:0]      fill_data;
  logic [8:0]       remaining;
  logic             issue_gate;
  logic             fifo_full, fifo_empty, fifo_pop, fill_issue;
  logic             data_push, fill_start, write_drop;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  meta_entry_t      head;

`ifdef VDP_SPRITE_META_VBLANK_GATE_EN
  assign issue_gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign issue_gate    = 1'b1;
`endif

  assign host.host_ready = !fifo_full && (state == ST_IDLE);
  assign busy            = !fifo_empty || (state != ST_IDLE);

  assign data_push  = host.host_we && (host.host_register == REG_DATA) && host.host_ready;
  assign fill_start = host.host_we && (host.host_register == REG_FILL_COUNT) && host.host_ready;
  assign write_drop = host.host_we && !host.host_ready &&
                      ((host.host_register == REG_DATA) || (host.host_register == REG_FILL_COUNT));

  assign fifo_wdata = {pointer, block_select, host.host_write_data};
  assign head       = fifo_rdata;

  vdp_sprite_meta_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (data_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FILL lingers one cycle at remaining==0 so busy covers the final meta_we.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (fill_start) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_next = ST_FILL;
      ST_FILL:  if (remaining == 9'd0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop   = 1'b0;
    fill_issue = 1'b0;
    case (state)
      ST_IDLE, ST_DRAIN: fifo_pop   = !fifo_empty && issue_gate;
      ST_FILL:           fill_issue = (remaining != 9'd0) && issue_gate;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pointer      <= 8'd0;
      block_select <= 3'b000;
      increment    <= 8'(DEFAULT_INCREMENT);
      fill_data    <= 16'd0;
      remaining    <= 9'd0;
      overrun      <= 1'b0;
    end else begin
      if (fill_issue || data_push)
        pointer <= pointer + increment;
      else if (host.host_we && host.host_register == REG_ADDRESS)
        pointer <= host.host_write_data[7:0];

      if (host.host_we && host.host_register == REG_BLOCK_SELECT) begin
        block_select <= host.host_write_data[2:0];
        overrun      <= 1'b0;
      end else if (write_drop) begin
        overrun      <= 1'b1;
      end

      if (host.host_we && host.host_register == REG_INCREMENT)
        increment <= host.host_write_data[7:0];
      if (host.host_we && host.host_register == REG_FILL_DATA)
        fill_data <= host.host_write_data;

      // A count of zero selects a full 256-entry sweep.
      if (fill_start)
        remaining <= (host.host_write_data[7:0] == 8'd0) ? 9'd256 : {1'b0, host.host_write_data[7:0]};
      else if (fill_issue)
        remaining <= remaining - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_we           <= 1'b0;
      meta_address      <= 8'd0;
      meta_write_data   <= 16'd0;
      meta_block_select <= 3'b000;
    end else if (fifo_pop) begin
      meta_we           <= 1'b1;
      meta_address      <= head.address;
      meta_write_data   <= head.data;
      meta_block_select <= head.select;
    end else if (fill_issue) begin
      meta_we           <= 1'b1;
      meta_address      <= pointer;
      meta_write_data   <= fill_data;
      meta_block_select <= block_select;
    end else begin
      meta_we           <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vdp_sprite_meta_writer.sv
// tb/tb_vdp_sprite_meta_writer.sv - directed self-checking bench for vdp_sprite_meta_writer
module tb_vdp_sprite_meta_writer;
  import vdp_sprite_meta_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        vblank;
  logic [7:0]  meta_address;
  logic [15:0] meta_write_data;
  logic [2:0]  meta_block_select;
  logic        meta_we;
  logic        busy;
  logic        overrun;

  vdp_sprite_meta_writer_if hbus ();

  vdp_sprite_meta_writer #(.FIFO_DEPTH(4), .DEFAULT_INCREMENT(1)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .host              (hbus),
    .vblank            (vblank),
    .meta_address      (meta_address),
    .meta_write_data   (meta_write_data),
    .meta_block_select (meta_block_select),
    .meta_we           (meta_we),
    .busy              (busy),
    .overrun           (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [2:0]  s;
    logic [15:0] d;
    int          cyc;
  } rec_t;

  rec_t wlog[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (meta_we) wlog.push_back('{meta_address, meta_block_select, meta_write_data, cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] d);
    @(negedge clk);
    hbus.host_register   = r;
    hbus.host_write_data = d;
    hbus.host_we         = 1'b1;
    @(negedge clk);
    hbus.host_we         = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && !meta_we) break;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt, hr_bad, ok, extra;
    int hits[256];

    reset_n = 1'b0;
    vblank  = 1'b1;
    hbus.host_register   = 3'd0;
    hbus.host_write_data = 16'd0;
    hbus.host_we         = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_meta_we", {31'd0, meta_we}, 32'd0);
    check("rst_addr", {24'd0, meta_address}, 32'd0);
    check("rst_data", {16'd0, meta_write_data}, 32'd0);
    check("rst_sel", {29'd0, meta_block_select}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_ready", {31'd0, hbus.host_ready}, 32'd1);
    reset_n = 1'b1;

    // Single write, one-cycle latency, one-cycle pulse
    wr(REG_ADDRESS, 16'h0010);
    wr(REG_BLOCK_SELECT, 16'h0002);
    wr(REG_DATA, 16'h0C25);
    @(negedge clk);
    check("single_we", {31'd0, meta_we}, 32'd1);
    check("single_addr", {24'd0, meta_address}, 32'h10);
    check("single_sel", {29'd0, meta_block_select}, 32'h2);
    check("single_data", {16'd0, meta_write_data}, 32'h0C25);
    @(negedge clk);
    check("single_pulse", {31'd0, meta_we}, 32'd0);
    check("single_hold_addr", {24'd0, meta_address}, 32'h10);

    // Pointer advanced to 0x11, then increment 0x80 with wrap
    wlog.delete();
    wr(REG_DATA, 16'hBEEF);
    wr(REG_INCREMENT, 16'h0080);
    wr(REG_ADDRESS, 16'h00C0);
    wr(REG_DATA, 16'h1111);
    wr(REG_DATA, 16'h2222);
    wr(REG_DATA, 16'h3333);
    wait_idle("wrap_idle");
    check("wrap_count", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("ptr_next_addr", {24'd0, wlog[0].a}, 32'h11);
      check("wrap_addr0", {24'd0, wlog[1].a}, 32'hC0);
      check("wrap_addr1", {24'd0, wlog[2].a}, 32'h40);
      check("wrap_addr2", {24'd0, wlog[3].a}, 32'hC0);
      check("wrap_data2", {16'd0, wlog[3].d}, 32'h3333);
    end
    wr(REG_INCREMENT, 16'h0001);

    // Data entries ahead of a 3-entry fill
    wr(REG_BLOCK_SELECT, 16'h0001);
    wr(REG_FILL_DATA, 16'hFFFF);
    wr(REG_ADDRESS, 16'h0020);
    wlog.delete();
    wr(REG_DATA, 16'h00A1);
    wr(REG_DATA, 16'h00A2);
    wr(REG_FILL_COUNT, 16'h0003);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (meta_we && meta_write_data == 16'hFFFF) cnt++;
      if (cnt == 3) begin
        check("fill_busy_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("fill_busy_drop", {31'd0, busy}, 32'd0);
        break;
      end
    end
    check("fill_pulses", cnt, 32'd3);
    check("fill_count", wlog.size(), 32'd5);
    if (wlog.size() == 5) begin
      check("fill_d0", {16'd0, wlog[0].d}, 32'h00A1);
      check("fill_d1", {16'd0, wlog[1].d}, 32'h00A2);
      check("fill_a2", {24'd0, wlog[2].a}, 32'h22);
      check("fill_a4", {24'd0, wlog[4].a}, 32'h24);
      check("fill_sel4", {29'd0, wlog[4].s}, 32'h1);
      check("fill_consec", wlog[4].cyc - wlog[2].cyc, 32'd2);
    end

`ifdef VDP_SPRITE_META_VBLANK_GATE_EN
    // Gate closed: FIFO fills, fifth write is dropped
    vblank = 1'b0;
    wlog.delete();
    for (int i = 0; i < 4; i++) wr(REG_DATA, 16'h0100 + 16'(i));
    check("full_ready", {31'd0, hbus.host_ready}, 32'd0);
    wr(REG_DATA, 16'h0104);
    check("full_overrun", {31'd0, overrun}, 32'd1);
    repeat (5) @(negedge clk);
    check("full_no_we", wlog.size(), 32'd0);
    vblank = 1'b1;
    wait_idle("full_idle");
    check("full_count", wlog.size(), 32'd4);
`else
    // Writes during a fill are dropped
    wr(REG_ADDRESS, 16'h0000);
    wlog.delete();
    wr(REG_FILL_COUNT, 16'h0020);
    check("drop_ready", {31'd0, hbus.host_ready}, 32'd0);
    wr(REG_DATA, 16'h5555);
    check("drop_overrun", {31'd0, overrun}, 32'd1);
    wait_idle("drop_idle");
    check("drop_count", wlog.size(), 32'd32);
`endif
    wr(REG_BLOCK_SELECT, 16'h0007);
    check("overrun_clear", {31'd0, overrun}, 32'd0);

    // Count 0 sweeps all 256 entries
    wr(REG_ADDRESS, 16'h0000);
    wlog.delete();
    wr(REG_FILL_COUNT, 16'h0000);
    cnt = 0;
    hr_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (meta_we) cnt++;
      if (hbus.host_ready && cnt < 256) hr_bad++;
      if (cnt == 256 && !busy) break;
    end
    check("sweep_pulses", cnt, 32'd256);
    check("sweep_ready_low", hr_bad, 32'd0);
    for (int i = 0; i < 256; i++) hits[i] = 0;
    foreach (wlog[i]) hits[wlog[i].a]++;
    ok = 0;
    foreach (wlog[i]) if (hits[wlog[i].a] == 1 && wlog[i].s == 3'b111) ok++;
    check("sweep_cover", ok, 32'd256);

    // Reset in the middle of a fill
    wr(REG_ADDRESS, 16'h0000);
    wr(REG_FILL_COUNT, 16'd100);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (meta_we) cnt++;
      if (cnt == 10) break;
    end
    check("midrst_reached", cnt, 32'd10);
    reset_n = 1'b0;
    #1;
    check("midrst_we", {31'd0, meta_we}, 32'd0);
    check("midrst_addr", {24'd0, meta_address}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, hbus.host_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (meta_we) extra++;
    end
    check("midrst_no_we", extra, 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vdp_sprite_meta_writer.md
Name: vdp_sprite_meta_writer

Overview:
Host-facing producer for the sprite core's metadata write port (meta_address / meta_write_data / meta_block_select / meta_we).
- CPU register writes go through an auto-incrementing pointer and a small FIFO.
- A hardware fill engine can bulk-initialise entries.
- Emits at most one metadata write per clock.
- Sits between the VDP host register decoder and the sprite core's x/y/g attribute blocks.

Parameters:
FIFO_DEPTH, 4, queued metadata writes (power of 2, 2..16)
DEFAULT_INCREMENT, 1, pointer step after each DATA write or fill entry

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
host_register  in  3  register select: 0 ADDRESS, 1 BLOCK_SELECT, 2 DATA, 3 INCREMENT, 4 FILL_DATA, 5 FILL_COUNT
host_write_data  in  16  register write value
host_we  in  1  register write strobe, one cycle per write
host_ready  out  1  high when a DATA or FILL_COUNT write will be accepted
vblank  in  1  vertical blank indicator (used only with the optional feature)
meta_address  out  8  sprite entry index
meta_write_data  out  16  attribute word
meta_block_select  out  3  bit0 x_block, bit1 y_block, bit2 g_block; multiple bits allowed
meta_we  out  1  metadata write strobe
busy  out  1  FIFO non-empty or fill active
overrun  out  1  sticky: DATA or FILL_COUNT write dropped; cleared by writing BLOCK_SELECT

Behaviour:
Reset (async, reset_n low):
- pointer=0, block_select=3'b000, increment=DEFAULT_INCREMENT, fill_data=0, FIFO empty, state IDLE.
- Outputs: meta_we=0, meta_address=0, meta_write_data=0, meta_block_select=0, busy=0, overrun=0, host_ready=1.
- Reset mid-fill or with a non-empty FIFO abandons all pending writes.

Register writes (host_we=1):
- ADDRESS: pointer <= data[7:0].
- BLOCK_SELECT: block_select <= data[2:0]; overrun <= 0.
- INCREMENT: increment <= data[7:0]. An increment of 0 is legal and repeatedly writes the same entry.
- FILL_DATA: fill_data <= data.
- Unused registers 6–7: ignored.

DATA write:
- If host_ready, push {pointer, block_select, data} to the FIFO, then pointer <= pointer+increment mod 256.
- If not host_ready, the write is dropped and overrun <= 1.
- Queued entries keep their captured address and block_select; later ADDRESS or BLOCK_SELECT writes do not alter them.

FILL_COUNT write:
- If host_ready, enter FILL with remaining = data[7:0], where 0 means 256.
- Otherwise drop and set overrun.

host_ready = (FIFO not full) && (state==IDLE).

State machine:
- IDLE:
  - If the FIFO is non-empty and the issue gate is open, pop one entry. The next cycle has meta_we=1 with the entry's fields.
  - FILL_COUNT accepted -> DRAIN.
- DRAIN: wait until the FIFO is empty, preserving write order, then -> FILL.
- FILL: each cycle the gate is open:
  - meta_we=1 next cycle with {pointer, block_select, fill_data}.
  - pointer += increment, remaining -= 1.
  - When remaining reaches 0 -> IDLE.

Timing:
- All meta_* outputs are registered. Latency from an accepted DATA write at edge t (empty FIFO, gate open) to meta_we high is cycle t+1, i.e. one cycle.
- meta_we is high for exactly one cycle per entry. Other meta_* outputs hold their last values while meta_we=0.
- Simultaneous push and pop on a full FIFO: the push is not accepted, because host_ready is already low. On a non-full FIFO, push and pop in the same cycle are both performed.

busy = FIFO non-empty OR state != IDLE.

Pointer wrap: 255 + 1 -> 0 silently.

Optional Feature:
VDP_SPRITE_META_VBLANK_GATE_EN
- Defined: the issue gate is open only while vblank=1. FIFO and fill progress stall outside vblank, and host writes still queue until the FIFO is full. A fill that spans the end of vblank pauses and resumes at the next vblank with the pointer intact.
- Undefined: the gate is always open and the vblank input is ignored.

Decomposition:
- Shared package vdp_sprite_meta_pkg:
  - register offset constants (ADDRESS..FILL_COUNT);
  - block-select bit positions (X=0, Y=1, G=2);
  - FIFO entry width constant (27 bits: 8 address + 3 select + 16 data).
- One sub-module vdp_sprite_meta_fifo: synchronous FIFO with push/pop/full/empty, parameterised depth and width, same async active-low reset.

Test Plan:
- Single write: reset; ADDRESS=0x10; BLOCK_SELECT=3'b010; DATA=0x0C25 -> meta_we one cycle later with address 0x10, select 3'b010, data 0x0C25; pointer becomes 0x11.
- Increment and wrap: INCREMENT=0x80; ADDRESS=0xC0; three DATA writes -> addresses 0xC0, 0x40, 0xC0 in order.
- FIFO full and overrun (vblank gate defined, vblank=0): five DATA writes with FIFO_DEPTH=4 -> host_ready low after the fourth, overrun=1, zero meta_we. Raise vblank -> exactly four writes. Writing BLOCK_SELECT clears overrun.
- Fill after queued data: two DATA writes followed by FILL_COUNT=3 with FILL_DATA=0xFFFF -> the two data entries are issued first, then three consecutive fill writes at sequential addresses; busy drops the cycle after the last meta_we.
- Fill count 0: FILL_COUNT=0, select 3'b111 -> 256 meta_we pulses covering addresses 0..255 once; host_ready low throughout.
- Reset mid-fill: assert reset_n low after 10 fill writes -> all outputs go to reset values immediately; no further meta_we after release.
